// File: rtl/protected_read_output_queue_if.sv
// Handshake and data bundle between the protected-read stage, the output queue and the consumer.
// The master side is the producer/consumer pair; the slave side is the queue itself.
interface protected_read_output_queue_if #(
    parameter int process_token_register_width = 160,
    parameter int data_found_register_width    = 8,
    parameter int addr_width                   = 2
);
    logic                                    write_enable;
    logic                                    read_enable;
    logic [process_token_register_width-1:0] process_token_register_in;
    logic [data_found_register_width-1:0]    data_found_register_in;
    logic                                    success_of_execution_ff_in;
    logic                                    status_of_input_data_ff_set;
    logic                                    status_of_input_data_ff_reset;
    logic                                    clear_overflow;
    logic [process_token_register_width-1:0] process_token_register_out;
    logic [data_found_register_width-1:0]    data_found_register_out;
    logic                                    success_of_execution_ff_out;
    logic                                    status_of_input_data_ff_out;
    logic                                    empty;
    logic                                    full;
    logic [addr_width:0]                     count;
    logic                                    overflow;

    modport master (
        output write_enable, read_enable, process_token_register_in, data_found_register_in,
               success_of_execution_ff_in, status_of_input_data_ff_set,
               status_of_input_data_ff_reset, clear_overflow,
        input  process_token_register_out, data_found_register_out, success_of_execution_ff_out,
               status_of_input_data_ff_out, empty, full, count, overflow
    );

    modport slave (
        input  write_enable, read_enable, process_token_register_in, data_found_register_in,
               success_of_execution_ff_in, status_of_input_data_ff_set,
               status_of_input_data_ff_reset, clear_overflow,
        output process_token_register_out, data_found_register_out, success_of_execution_ff_out,
               status_of_input_data_ff_out, empty, full, count, overflow
    );
endinterface

// File: rtl/protected_read_output_queue.sv
// Show-ahead FIFO of completed protected-read results (token, data word, success bit),
// plus the status-of-input-data flag and a sticky overflow flag for dropped pushes.
module protected_read_output_queue #(
    parameter int process_token_register_width = 160,
    parameter int data_found_register_width    = 8,
    parameter int depth                        = 4,
    parameter int addr_width                   = 2
) (
    input logic                          clk,
    input logic                          reset,
    protected_read_output_queue_if.slave q
);
    localparam logic [addr_width:0] depth_count = (addr_width + 1)'(depth);

    logic [process_token_register_width-1:0] token_mem   [depth];
    logic [data_found_register_width-1:0]    data_mem    [depth];
    logic                                    success_mem [depth];

    logic [addr_width-1:0] wr_ptr;
    logic [addr_width-1:0] rd_ptr;
    logic [addr_width:0]   count;
    logic                  overflow;
    logic                  status_flag;
    logic                  empty;
    logic                  full;
    logic                  pop_ok;
    logic                  push_ok;
    logic                  drop;

    assign empty   = (count == '0);
    assign full    = (count == depth_count);
    assign pop_ok  = q.read_enable && !empty;
    // A pop in the same cycle frees the slot, so a full queue can still accept the push.
    assign push_ok = q.write_enable && (!full || pop_ok);
    assign drop    = q.write_enable && full && !pop_ok;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            token_mem[wr_ptr]   <= q.process_token_register_in;
            data_mem[wr_ptr]    <= q.data_found_register_in;
            success_mem[wr_ptr] <= q.success_of_execution_ff_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)                  overflow <= 1'b1;
            else if (q.clear_overflow) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              status_flag <= 1'b0;
        else if (q.status_of_input_data_ff_reset) status_flag <= 1'b0;
        else if (q.status_of_input_data_ff_set)   status_flag <= 1'b1;
    end

    assign q.process_token_register_out  = empty ? '0 : token_mem[rd_ptr];
    assign q.data_found_register_out     = empty ? '0 : data_mem[rd_ptr];
    assign q.success_of_execution_ff_out = empty ? 1'b0 : success_mem[rd_ptr];
    assign q.status_of_input_data_ff_out = status_flag;
    assign q.empty                       = empty;
    assign q.full                        = full;
    assign q.count                       = count;
    assign q.overflow                    = overflow;
endmodule

// File: tb/tb_protected_read_output_queue.sv
// Directed bench for protected_read_output_queue at depth 4 with hand-computed expectations.
module tb_protected_read_output_queue;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    protected_read_output_queue_if #(
        .process_token_register_width(160),
        .data_found_register_width(8),
        .addr_width(2)
    ) bus ();

    protected_read_output_queue #(
        .process_token_register_width(160),
        .data_found_register_width(8),
        .depth(4),
        .addr_width(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .q(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.write_enable                  = 1'b0;
        bus.read_enable                   = 1'b0;
        bus.status_of_input_data_ff_set   = 1'b0;
        bus.status_of_input_data_ff_reset = 1'b0;
        bus.clear_overflow                = 1'b0;
    endtask

    task automatic push(input logic [159:0] tok, input logic [7:0] dat, input logic s);
        bus.write_enable               = 1'b1;
        bus.process_token_register_in  = tok;
        bus.data_found_register_in     = dat;
        bus.success_of_execution_ff_in = s;
    endtask

    task automatic chk_state(input string tag, input logic [2:0] cnt, input logic e, input logic f);
        chk({tag, ".count"}, 160'(bus.count), 160'(cnt));
        chk({tag, ".empty"}, 160'(bus.empty), 160'(e));
        chk({tag, ".full"},  160'(bus.full),  160'(f));
    endtask

    task automatic chk_head(input string tag, input logic [159:0] tok, input logic [7:0] dat, input logic s);
        chk({tag, ".token"},   bus.process_token_register_out, tok);
        chk({tag, ".data"},    160'(bus.data_found_register_out), 160'(dat));
        chk({tag, ".success"}, 160'(bus.success_of_execution_ff_out), 160'(s));
    endtask

    initial begin
        logic [159:0] exp_tok;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle();
        push(160'h0, 8'h0, 1'b0);
        bus.write_enable = 1'b0;
        #2;
        chk_state("async_reset", 3'd0, 1'b1, 1'b0);
        chk_head("async_reset", 160'h0, 8'h00, 1'b0);
        chk("async_reset.overflow", 160'(bus.overflow), 160'h0);
        chk("async_reset.status", 160'(bus.status_of_input_data_ff_out), 160'h0);
        tick();
        reset = 1'b0;
        tick();

        // Three pushes then three pops
        push(160'hA1, 8'h11, 1'b1); tick();
        chk_state("push1", 3'd1, 1'b0, 1'b0);
        chk_head("push1", 160'hA1, 8'h11, 1'b1);
        push(160'hA2, 8'h22, 1'b0); tick();
        chk_state("push2", 3'd2, 1'b0, 1'b0);
        chk_head("push2", 160'hA1, 8'h11, 1'b1);
        push(160'hA3, 8'h33, 1'b1); tick();
        chk_state("push3", 3'd3, 1'b0, 1'b0);
        idle(); bus.read_enable = 1'b1; tick();
        chk_state("pop1", 3'd2, 1'b0, 1'b0);
        chk_head("pop1", 160'hA2, 8'h22, 1'b0);
        tick();
        chk_state("pop2", 3'd1, 1'b0, 1'b0);
        chk_head("pop2", 160'hA3, 8'h33, 1'b1);
        tick();
        chk_state("pop3", 3'd0, 1'b1, 1'b0);
        chk_head("pop3", 160'h0, 8'h00, 1'b0);
        tick();
        chk_state("pop_empty", 3'd0, 1'b1, 1'b0);
        chk("pop_empty.overflow", 160'(bus.overflow), 160'h0);

        // Fill and overflow
        idle();
        for (int i = 1; i <= 4; i++) begin
            push(160'(8'hB0 + i), 8'(8'h40 + i), 1'b0);
            tick();
        end
        chk_state("fill", 3'd4, 1'b0, 1'b1);
        push(160'hB5, 8'h45, 1'b1); tick();
        chk_state("drop", 3'd4, 1'b0, 1'b1);
        chk("drop.overflow", 160'(bus.overflow), 160'h1);
        chk_head("drop", 160'hB1, 8'h41, 1'b0);
        bus.clear_overflow = 1'b1; tick();
        chk("drop_and_clear.overflow", 160'(bus.overflow), 160'h1);
        idle(); bus.clear_overflow = 1'b1; tick();
        chk("clear.overflow", 160'(bus.overflow), 160'h0);
        chk_state("clear", 3'd4, 1'b0, 1'b1);

        // Push+pop while full over 10 cycles: stream B1..B4 then C0..C9
        idle();
        for (int i = 0; i < 10; i++) begin
            push(160'(8'hC0 + i), 8'(8'h60 + i), 1'b0);
            bus.read_enable = 1'b1;
            tick();
            exp_tok = (i + 1 < 4) ? 160'(8'hB1 + i + 1) : 160'(8'hC0 + i + 1 - 4);
            chk($sformatf("stream%0d.count", i), 160'(bus.count), 160'h4);
            chk($sformatf("stream%0d.token", i), bus.process_token_register_out, exp_tok);
        end
        chk("stream.overflow", 160'(bus.overflow), 160'h0);
        idle(); bus.read_enable = 1'b1;
        for (int i = 7; i <= 9; i++) begin
            tick();
            chk_head($sformatf("drain%0d", i), 160'(8'hC0 + i), 8'(8'h60 + i), 1'b0);
        end
        tick();
        chk_state("drained", 3'd0, 1'b1, 1'b0);
        chk_head("drained", 160'h0, 8'h00, 1'b0);

        // Push and pop together while empty
        idle();
        push(160'h55, 8'h5A, 1'b1); bus.read_enable = 1'b1; tick();
        chk_state("empty_pushpop", 3'd1, 1'b0, 1'b0);
        chk_head("empty_pushpop", 160'h55, 8'h5A, 1'b1);
        idle(); bus.read_enable = 1'b1; tick();
        chk_state("empty_pushpop_pop", 3'd0, 1'b1, 1'b0);

        // Status flag
        idle(); bus.status_of_input_data_ff_set = 1'b1; tick();
        chk("status.set", 160'(bus.status_of_input_data_ff_out), 160'h1);
        idle(); tick();
        chk("status.hold", 160'(bus.status_of_input_data_ff_out), 160'h1);
        bus.status_of_input_data_ff_set = 1'b1; bus.status_of_input_data_ff_reset = 1'b1; tick();
        chk("status.both", 160'(bus.status_of_input_data_ff_out), 160'h0);
        idle(); bus.status_of_input_data_ff_reset = 1'b1; tick();
        chk("status.reset", 160'(bus.status_of_input_data_ff_out), 160'h0);

        // Two entries held with overflow set, then async reset between edges
        idle();
        for (int i = 1; i <= 5; i++) begin
            push(160'(8'hD0 + i), 8'(8'h70 + i), 1'b1);
            tick();
        end
        idle(); bus.read_enable = 1'b1; tick(); tick();
        idle(); bus.status_of_input_data_ff_set = 1'b1; tick();
        idle();
        chk_state("pre_reset", 3'd2, 1'b0, 1'b0);
        chk("pre_reset.overflow", 160'(bus.overflow), 160'h1);
        chk_head("pre_reset", 160'hD3, 8'h73, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_state("mid_reset", 3'd0, 1'b1, 1'b0);
        chk("mid_reset.overflow", 160'(bus.overflow), 160'h0);
        chk("mid_reset.status", 160'(bus.status_of_input_data_ff_out), 160'h0);
        chk_head("mid_reset", 160'h0, 8'h00, 1'b0);
        tick();
        reset = 1'b0;
        push(160'hE1, 8'h81, 1'b0); tick();
        idle();
        chk_state("resume", 3'd1, 1'b0, 1'b0);
        chk_head("resume", 160'hE1, 8'h81, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/protected_read_output_queue.md
# protected_read_output_queue

Parametrised, multi-entry successor to the single-entry protected-read output buffer. Holds up to `depth` completed protected-read results, each a process token, a data-found word and a success-of-execution bit, in a first-in-first-out show-ahead queue. Also carries the status-of-input-data set/reset flag. Sits between the protected-read execution stage (producer) and the result consumer, so back-to-back reads no longer stall on a single register.

## Interface
Parameters:
- `process_token_register_width`, 160: width of each stored process token.
- `data_found_register_width`, 8: width of each stored data-found word.
- `depth`, 4: number of entries; power of two, 2 to 64.
- `addr_width`, 2: log2(`depth`); must be set consistently with `depth`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `write_enable`  in  1  push request for the current input entry.
- `read_enable`  in  1  pop request for the head entry.
- `process_token_register_in`  in  `process_token_register_width`  token to push.
- `data_found_register_in`  in  `data_found_register_width`  data word to push.
- `success_of_execution_ff_in`  in  1  success bit to push.
- `status_of_input_data_ff_set`  in  1  sets the status flag.
- `status_of_input_data_ff_reset`  in  1  clears the status flag.
- `clear_overflow`  in  1  clears the sticky overflow flag.
- `process_token_register_out`  out  `process_token_register_width`  head token.
- `data_found_register_out`  out  `data_found_register_width`  head data.
- `success_of_execution_ff_out`  out  1  head success bit.
- `status_of_input_data_ff_out`  out  1  status flag.
- `empty`  out  1  queue holds 0 entries.
- `full`  out  1  queue holds `depth` entries.
- `count`  out  `addr_width`+1  current occupancy, 0..`depth`.
- `overflow`  out  1  sticky flag: a push was dropped.

## Operation
- Storage: `depth`-entry register array; write pointer and read pointer are `addr_width` bits and wrap modulo `depth`. `count` is held as a separate register.
- Show-ahead: head-entry outputs are driven from the entry at the read pointer. While `empty`=1, all three data outputs are forced to 0.
- Push is accepted when `write_enable`=1 and (`full`=0 or a pop is accepted in the same cycle). An accepted push writes the entry at the write pointer and increments the pointer.
- Pop is accepted when `read_enable`=1 and `empty`=0. An accepted pop increments the read pointer. Popped data is not cleared from storage.
- Push and pop accepted in the same cycle leave `count` unchanged.
- Push and pop requested while empty: only the push is accepted, and `count` becomes 1.
- Push requested while full, with no accepted pop: the entry is dropped, state is unchanged, and `overflow` is set.
- Pop requested while empty: ignored, with no flag.
- `overflow` clears when `clear_overflow`=1. If a drop and `clear_overflow` occur in the same cycle, `overflow` stays set.
- Status flag: `reset`-input dominant. If both set and reset inputs are 1, the flag goes to 0. If both are 0, it holds.
- Arithmetic: `count` increments or decrements by 1 only and never exceeds `depth` or drops below 0. `full` = (`count`==`depth`) and `empty` = (`count`==0), both registered-consistent with `count`.

## Timing
- Reset values: pointers 0, `count` 0, `empty` 1, `full` 0, `overflow` 0, `status_of_input_data_ff_out` 0, all data outputs 0. Storage contents are don't-care.
- Assertion of `reset` mid-operation discards all entries immediately, with no clock edge required. Operation resumes on the first rising edge after deassertion.
- Push latency: data accepted at edge N appears at the outputs after edge N if the queue was empty. `empty` falls after the same edge.
- Pop latency: the next entry appears at the outputs after the popping edge. There are no bubbles, so full throughput is one push and one pop per cycle.
- `full`, `empty`, `count` and `overflow` all update on the same edge as the causing push or pop.
- The status flag updates one edge after set or reset is asserted.

## Test plan
- Reset, then push tokens 0xA1, 0xA2, 0xA3 with data 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 -> outputs show 0xA1/0x11, then 0xA2/0x22, then 0xA3/0x33; `count` reads 1, 2, 3, 2, 1, 0; `empty`=1 at the end, and outputs are 0.
- Push 4 entries (`depth`=4), then a 5th push -> `full`=1, `count`=4, `overflow`=1, and the head is unchanged. Pulse `clear_overflow` -> `overflow`=0.
- With the queue full, push and pop in the same cycle -> `count` stays 4, and the new entry appears after 3 more pops. Pointers wrap correctly over 10 such cycles.
- With the queue empty, assert push and pop together with token 0x55 -> `count`=1 and the output shows 0x55; no underflow occurs.
- Pulse status set, then set and reset together, then reset alone -> `status_of_input_data_ff_out` reads 1, 0, 0.
- With 2 entries held and `overflow`=1, assert `reset` asynchronously between edges -> `empty`=1, `count`=0, `overflow`=0, and outputs go to 0 before the next edge.
